// File: rtl/alu_serial.sv
// Bit-serial ALU: LSB-first, one bit per clock through a single slice and carry register.
// Optional SUB mode (mode 101) is built only when ALU_SUB_EN is defined.
module alu_serial #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    M_ADD  = 3'b000,
    M_AND  = 3'b001,
    M_OR   = 3'b010,
    M_XOR  = 3'b011,
    M_XNOR = 3'b100,
    M_SUB  = 3'b101
  } mode_e;

  state_e           r_state;
  state_e           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_mode;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;

  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_zero;
  logic             r_err;

  logic             w_last;
  logic             w_legal;
  logic             w_arith;
  logic             w_seed;
  logic             w_b_bit;
  logic             w_sum;
  logic             w_cgen;
  logic             w_bit;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- mode decode on the captured mode ----------------
  always_comb begin
    w_legal = 1'b0;
    w_arith = 1'b0;
    case (r_mode)
      M_ADD: begin
        w_legal = 1'b1;
        w_arith = 1'b1;
      end
      M_AND, M_OR, M_XOR, M_XNOR: w_legal = 1'b1;
`ifdef ALU_SUB_EN
      M_SUB: begin
        w_legal = 1'b1;
        w_arith = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Carry seed at acceptance: c_in for ADD, 1 for SUB (two's complement), 0 otherwise.
  always_comb begin
    w_seed = 1'b0;
    if (mode == M_ADD) w_seed = c_in;
`ifdef ALU_SUB_EN
    if (mode == M_SUB) w_seed = 1'b1;
`endif
  end

  // ---------------- single-bit slice ----------------
  always_comb begin
    w_b_bit = r_b[0];
`ifdef ALU_SUB_EN
    if (r_mode == M_SUB) w_b_bit = ~r_b[0];
`endif
  end

  assign w_sum  = r_a[0] ^ w_b_bit ^ r_carry;
  assign w_cgen = (r_a[0] & w_b_bit) | (r_a[0] & r_carry) | (w_b_bit & r_carry);

  always_comb begin
    w_bit = 1'b0;
    case (r_mode)
      M_ADD:   w_bit = w_sum;
      M_AND:   w_bit = r_a[0] & r_b[0];
      M_OR:    w_bit = r_a[0] | r_b[0];
      M_XOR:   w_bit = r_a[0] ^ r_b[0];
      M_XNOR:  w_bit = ~(r_a[0] ^ r_b[0]);
`ifdef ALU_SUB_EN
      M_SUB:   w_bit = w_sum;
`endif
      default: w_bit = 1'b0;
    endcase
  end

  assign w_shift_nxt = {w_bit, r_shift[WIDTH-1:1]};

  // ---------------- datapath registers ----------------
  // Visible outputs load on the final RUN edge so they are already valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_carry <= w_seed;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_arith) r_carry <= w_cgen;
          if (w_last) begin
            r_result    <= w_legal ? w_shift_nxt : '0;
            r_carry_out <= w_arith ? w_cgen : 1'b0;
            r_zero      <= w_legal ? (w_shift_nxt == '0) : 1'b1;
            r_err       <= ~w_legal;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule
